// File: rtl/wb_stage.sv
// Write-back stage: drives the register file write port from the MEM/WB boundary.
// Optional forwarding export to execute is enabled by defining WB_FWD_EN.
module wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [1:0]        result_src_m,
    input  logic [2:0]        funct3_m,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [XLEN-1:0]   pc_plus4_m,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid,
    output logic              stall_wb,
    output logic              we,
    output logic [REG_AW-1:0] a3,
    output logic [XLEN-1:0]   wd3,
    output logic              misalign,
    output logic              retire,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data
);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    state_t            state;
    state_t            state_nxt;

    logic [REG_AW-1:0] rd_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              latch_load;

    logic              we_nxt;
    logic [REG_AW-1:0] a3_nxt;
    logic [XLEN-1:0]   wd3_nxt;
    logic              mis_nxt;
    logic              ret_nxt;

    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [XLEN-1:0]   load_ext;
    logic              load_mis;

    // Lane extraction works off the latched load attributes, not the live inputs.
    always_comb begin
        case (off_q)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (f3_q[1:0])
            2'b00: load_ext = {{(XLEN-8){lane_b[7] & ~f3_q[2]}}, lane_b};
            2'b01: load_ext = {{(XLEN-16){lane_h[15] & ~f3_q[2]}}, lane_h};
            default: load_ext = mem_rdata;
        endcase

        case (f3_q[1:0])
            2'b01:   load_mis = off_q[0];
            2'b10:   load_mis = (off_q != 2'b00);
            default: load_mis = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        latch_load = 1'b0;
        we_nxt     = 1'b0;
        a3_nxt     = '0;
        wd3_nxt    = '0;
        mis_nxt    = 1'b0;
        ret_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (valid_m) begin
                    if (result_src_m == SRC_LOAD && reg_write_m && rd_m != '0) begin
                        latch_load = 1'b1;
                        state_nxt  = WAIT_LOAD;
                    end else begin
                        ret_nxt = 1'b1;
                        a3_nxt  = rd_m;
                        case (result_src_m)
                            SRC_ALU: wd3_nxt = alu_result_m;
                            SRC_PC4: wd3_nxt = pc_plus4_m;
                            default: wd3_nxt = '0;
                        endcase
                        we_nxt = reg_write_m && (rd_m != '0) &&
                                 (result_src_m == SRC_ALU || result_src_m == SRC_PC4);
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    ret_nxt   = 1'b1;
                    a3_nxt    = rd_q;
                    mis_nxt   = load_mis;
                    we_nxt    = ~load_mis;
                    wd3_nxt   = load_mis ? '0 : load_ext;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            stall_wb <= 1'b0;
            we       <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
            misalign <= 1'b0;
            retire   <= 1'b0;
            rd_q     <= '0;
            f3_q     <= '0;
            off_q    <= '0;
        end else begin
            state    <= state_nxt;
            stall_wb <= (state_nxt == WAIT_LOAD);
            we       <= we_nxt;
            a3       <= a3_nxt;
            wd3      <= wd3_nxt;
            misalign <= mis_nxt;
            retire   <= ret_nxt;
            if (latch_load) begin
                rd_q  <= rd_m;
                f3_q  <= funct3_m;
                off_q <= alu_result_m[1:0];
            end
        end
    end

`ifdef WB_FWD_EN
    // While a load is pending, fwd_rd carries its rd with fwd_valid low so execute can stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_valid <= 1'b0;
            fwd_rd    <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= we_nxt;
            fwd_data  <= wd3_nxt;
            if (latch_load)
                fwd_rd <= rd_m;
            else if (state_nxt == WAIT_LOAD)
                fwd_rd <= rd_q;
            else
                fwd_rd <= a3_nxt;
        end
    end
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writes, a monitor pops on retire.
// Forwarding checks follow the WB_FWD_EN build option.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_m;
    logic        reg_write_m;
    logic [4:0]  rd_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m;
    logic [31:0] pc_plus4_m;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        stall_wb;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        misalign;
    logic        retire;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [4:0]  pend_rd = '0;

    wb_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .reg_write_m(reg_write_m),
        .rd_m(rd_m), .result_src_m(result_src_m), .funct3_m(funct3_m),
        .alu_result_m(alu_result_m), .pc_plus4_m(pc_plus4_m),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .stall_wb(stall_wb),
        .we(we), .a3(a3), .wd3(wd3), .misalign(misalign), .retire(retire),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (retire) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_retire: got retire=1 a3=%0d want no retire", a3);
                    end else begin
                        e = q.pop_front();
                        check("we", {31'b0, we}, {31'b0, e.we});
                        check("misalign", {31'b0, misalign}, {31'b0, e.mis});
                        if (e.we) begin
                            check("a3", {27'b0, a3}, {27'b0, e.a3});
                            check("wd3", wd3, e.wd3);
                        end
`ifdef WB_FWD_EN
                        check("fwd_valid", {31'b0, fwd_valid}, {31'b0, e.we});
                        if (e.we) begin
                            check("fwd_rd", {27'b0, fwd_rd}, {27'b0, e.a3});
                            check("fwd_data", fwd_data, e.wd3);
                        end
`endif
                    end
                end else if (we || misalign) begin
                    total++;
                    bad++;
                    $display("FAIL pulse_without_retire: got we=%b misalign=%b want 0", we, misalign);
                end
`ifdef WB_FWD_EN
                if (stall_wb) begin
                    check("fwd_hazard_valid", {31'b0, fwd_valid}, 32'd0);
                    check("fwd_hazard_rd", {27'b0, fwd_rd}, {27'b0, pend_rd});
                end
`else
                if (fwd_valid || fwd_rd != 5'd0 || fwd_data != 32'd0) begin
                    total++;
                    bad++;
                    $display("FAIL fwd_tied: got %b/%0d/%h want 0", fwd_valid, fwd_rd, fwd_data);
                end
`endif
            end
        end
    end

    // Present one non-waiting instruction for a single edge; valid stays high for back-to-back use.
    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc,
                         input logic exp_we, input logic [31:0] exp_wd3);
        exp_t e;
        valid_m = 1'b1; reg_write_m = rw; rd_m = rd; result_src_m = src;
        funct3_m = f3; alu_result_m = alu; pc_plus4_m = pc;
        e.we = exp_we; e.a3 = rd; e.wd3 = exp_wd3; e.mis = 1'b0;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        valid_m = 1'b0;
        @(posedge clk); #1;
    endtask

    // Load with rvalid sampled 'delay' edges after the accept edge (delay >= 1).
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int unsigned delay,
                           input logic exp_mis, input logic [31:0] exp_wd3);
        exp_t e;
        valid_m = 1'b1; reg_write_m = 1'b1; rd_m = rd; result_src_m = 2'b01;
        funct3_m = f3; alu_result_m = addr; pc_plus4_m = 32'h0;
        e.we = ~exp_mis; e.a3 = rd; e.wd3 = exp_wd3; e.mis = exp_mis;
        q.push_back(e);
        pend_rd = rd;
        @(posedge clk); #1;
        valid_m = 1'b0;
        for (int unsigned i = 0; i < delay; i++) begin
            check("stall_high", {31'b0, stall_wb}, 32'd1);
            if (i == delay - 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data;
            end else begin
                mem_rdata = 32'h5A5A5A5A;
            end
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        check("stall_low", {31'b0, stall_wb}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid_m = 1'b1; reg_write_m = 1'b1; rd_m = 5'd10;
        result_src_m = 2'b00; funct3_m = 3'b010; alu_result_m = 32'h12;
        pc_plus4_m = 32'h4; mem_rdata = 32'h0; mem_rvalid = 1'b0;

        // Reset held with a valid instruction present
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_we", {31'b0, we}, 32'd0);
            check("rst_retire", {31'b0, retire}, 32'd0);
            check("rst_stall", {31'b0, stall_wb}, 32'd0);
            check("rst_a3", {27'b0, a3}, 32'd0);
            check("rst_wd3", wd3, 32'd0);
            check("rst_misalign", {31'b0, misalign}, 32'd0);
            check("rst_fwd", {fwd_valid, fwd_rd, fwd_data[25:0]}, 32'd0);
        end
        valid_m = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU / PC+4 / reserved / x0 / no-write, back to back
        issue(1'b1, 5'd10, 2'b00, 3'b000, 32'h00000012, 32'h0, 1'b1, 32'h00000012);
        issue(1'b1, 5'd0,  2'b00, 3'b000, 32'h00000034, 32'h0, 1'b0, 32'h0);
        issue(1'b1, 5'd5,  2'b00, 3'b000, 32'hDEADBEEF, 32'h0, 1'b1, 32'hDEADBEEF);
        issue(1'b1, 5'd21, 2'b10, 3'b000, 32'h11111111, 32'h00000ABC, 1'b1, 32'h00000ABC);
        issue(1'b1, 5'd7,  2'b11, 3'b000, 32'h22222222, 32'h33333333, 1'b0, 32'h0);
        issue(1'b0, 5'd8,  2'b00, 3'b000, 32'h44444444, 32'h0, 1'b0, 32'h0);
        idle();

        // rvalid while idle must be ignored
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        idle();

        // Loads returning 0x80FF00F0
        do_load(5'd11, 3'b000, 32'h103, 32'h80FF00F0, 3, 1'b0, 32'hFFFFFF80); // LB off3
        do_load(5'd12, 3'b101, 32'h102, 32'h80FF00F0, 1, 1'b0, 32'h000080FF); // LHU off2
        do_load(5'd13, 3'b001, 32'h102, 32'h80FF00F0, 2, 1'b0, 32'hFFFF80FF); // LH off2
        do_load(5'd14, 3'b001, 32'h100, 32'h80FF00F0, 1, 1'b0, 32'h000000F0); // LH off0
        do_load(5'd15, 3'b100, 32'h101, 32'h80FF00F0, 1, 1'b0, 32'h00000000); // LBU off1
        do_load(5'd16, 3'b000, 32'h100, 32'h80FF00F0, 1, 1'b0, 32'hFFFFFFF0); // LB off0
        do_load(5'd17, 3'b100, 32'h103, 32'h80FF00F0, 2, 1'b0, 32'h00000080); // LBU off3
        do_load(5'd18, 3'b010, 32'h100, 32'h80FF00F0, 1, 1'b0, 32'h80FF00F0); // LW
        do_load(5'd19, 3'b010, 32'h102, 32'h80FF00F0, 2, 1'b1, 32'h0);        // LW misaligned
        do_load(5'd20, 3'b001, 32'h101, 32'h80FF00F0, 1, 1'b1, 32'h0);        // LH misaligned

        // Loads that do not wait: rd=0 and reg_write=0
        issue(1'b1, 5'd0, 2'b01, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0);
        check("nowait_rd0_stall", {31'b0, stall_wb}, 32'd0);
        issue(1'b0, 5'd9, 2'b01, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0);
        check("nowait_nowr_stall", {31'b0, stall_wb}, 32'd0);
        idle();

        // Reset while a load is pending discards it
        valid_m = 1'b1; reg_write_m = 1'b1; rd_m = 5'd9; result_src_m = 2'b01;
        funct3_m = 3'b010; alu_result_m = 32'h200;
        pend_rd = 5'd9;
        @(posedge clk); #1;
        valid_m = 1'b0;
        check("wait_stall", {31'b0, stall_wb}, 32'd1);
        rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        check("midrst_stall", {31'b0, stall_wb}, 32'd0);
        check("midrst_we", {31'b0, we}, 32'd0);
        check("midrst_retire", {31'b0, retire}, 32'd0);
        rst_n = 1'b1; mem_rvalid = 1'b0;
        issue(1'b1, 5'd3, 2'b00, 3'b000, 32'hCAFEF00D, 32'h0, 1'b1, 32'hCAFEF00D);
        do_load(5'd4, 3'b010, 32'h300, 32'h0BADC0DE, 1, 1'b0, 32'h0BADC0DE);
        idle();

        // Drain: every expected write must have been observed, with a bounded wait
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
